fifo_burst_reader: RTL

- Read-side master for the team's synchronous FIFO.
- Watches the FIFO occupancy and, once a full burst is stored (or on flush), pops words with the FIFO's one-cycle registered-read latency.
- Re-presents the popped words as a valid/ready stream with a last-beat marker.
- A 2-entry output buffer absorbs downstream backpressure without losing popped words and sustains 1 beat/cycle.

---
 rtl/fifo_burst_reader_pkg.sv | 27 ++
 rtl/fifo_burst_reader_if.sv | 33 +++
 rtl/fifo_burst_reader_skid_buf.sv | 45 ++++
 rtl/fifo_burst_reader.sv | 109 ++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader and its output buffer.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = clog2(SKID_DEPTH + 1);
  localparam int unsigned SKID_PTR_W = clog2(SKID_DEPTH);

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read-side and output stream signals of the burst reader.
interface fifo_burst_reader_if #(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_date;
  logic                  fifo_empty;
  logic [ADDR_WIDTH:0]   fifo_cnt;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  busy;
  logic                  burst_done;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_date, fifo_empty, fifo_cnt, flush,
    output m_valid,
    input  m_ready,
    output m_data, m_last, busy, burst_done
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_date, fifo_empty, fifo_cnt, flush,
    input  m_valid,
    output m_ready,
    input  m_data, m_last, busy, burst_done
  );
endinterface

// File: rtl/fifo_burst_reader_skid_buf.sv
// Two-entry valid/ready buffer holding words popped from the FIFO until accepted.
module fifo_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [SKID_CNT_W-1:0] count
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr_q;
  logic [SKID_PTR_W-1:0] rd_ptr_q;
  logic [SKID_CNT_W-1:0] count_q;
  logic                  pop;

  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Circular storage; simultaneous write and pop keeps the count and order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_valid) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + SKID_PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + SKID_PTR_W'(1);
      count_q <= count_q + SKID_CNT_W'(wr_valid) - SKID_CNT_W'(pop);
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops bursts from a synchronous FIFO and re-presents them as a valid/ready stream with last.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_burst_reader_if.master bus
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned OW = SKID_CNT_W + 1;
  localparam logic [CW-1:0] BURST_LEN_W = CW'(BURST_LEN);

  state_t                state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         issued_q, accepted_q;
  logic                  inflight_q;
  logic                  done_q, done_d;
  logic [SKID_CNT_W-1:0] buf_cnt;
  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  pop;
  logic                  issue;
  logic                  last_beat;
  logic [OW-1:0]         occupancy;

  assign pop       = buf_valid && bus.m_ready;
  assign last_beat = buf_valid && (accepted_q == len_q - CW'(1));
  // Words already held or on their way, minus the one leaving this cycle.
  assign occupancy = OW'(buf_cnt) + OW'(inflight_q) - OW'(pop);
  assign issue     = (state_q == BURST) && !bus.fifo_empty && (issued_q < len_q)
                     && (occupancy < OW'(SKID_DEPTH));

  assign bus.fifo_rd_en = issue;
  assign bus.m_valid    = buf_valid;
  assign bus.m_data     = buf_data;
  assign bus.m_last     = last_beat;
  assign bus.busy       = (state_q != IDLE);
  assign bus.burst_done = done_q;

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (inflight_q),
    .wr_data  (bus.fifo_rd_date),
    .rd_valid (buf_valid),
    .rd_ready (bus.m_ready),
    .rd_data  (buf_data),
    .count    (buf_cnt)
  );

  // Next-state: a full burst has priority over a flush of the partial remainder.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fifo_cnt >= BURST_LEN_W) begin
          len_d   = BURST_LEN_W;
          state_d = BURST;
        end else if (bus.flush && !bus.fifo_empty) begin
          len_d   = bus.fifo_cnt;
          state_d = BURST;
        end
      end
      BURST: begin
        if (issue && (issued_q + CW'(1) == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (state_q == IDLE) begin
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (issue) issued_q <= issued_q + CW'(1);
        if (pop) accepted_q <= accepted_q + CW'(1);
      end
    end
  end

endmodule
